// File: rtl/control_unit_pipelined.sv
// Pipelined, handshaked control unit: decodes an opcode into a registered control
// word, with a multi-cycle MULT, illegal-opcode flagging and branch/jump flush.
module control_unit_pipelined #(
  parameter int OPCODE_WIDTH = 8,
  parameter int ALUOP_WIDTH  = 3,
  parameter int MULT_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  input  logic                    flush,
  output logic                    imm,
  output logic                    sign,
  output logic                    writeenable,
  output logic [ALUOP_WIDTH-1:0]  aluop,
  output logic                    jump,
  output logic                    branch,
  output logic                    illegal,
  output logic                    busy
);

  localparam int CW = 4;
  localparam logic [OPCODE_WIDTH-1:0] OP_MULT = OPCODE_WIDTH'(8);

  typedef enum logic [0:0] {IDLE, MULTI} state_t;

  typedef struct packed {
    logic                   imm;
    logic                   sign;
    logic                   we;
    logic [ALUOP_WIDTH-1:0] aluop;
    logic                   jump;
    logic                   branch;
    logic                   illegal;
  } ctrl_t;

  state_t         state, nextState;
  logic [CW-1:0]  counter, nextCounter;
  logic           outValidReg, nextOutValid;
  ctrl_t          ctrlReg, nextCtrl;
  logic           accept;
  logic           isMult;

  function automatic ctrl_t decode(input logic [OPCODE_WIDTH-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OPCODE_WIDTH'(0): begin c.imm = 1'b1; c.we = 1'b1; end
      OPCODE_WIDTH'(1): c.we = 1'b1;
      OPCODE_WIDTH'(2): begin c.we = 1'b1; c.aluop = ALUOP_WIDTH'(1); end
      OPCODE_WIDTH'(3): begin c.sign = 1'b1; c.we = 1'b1; c.aluop = ALUOP_WIDTH'(1); end
      OPCODE_WIDTH'(4): begin c.we = 1'b1; c.aluop = ALUOP_WIDTH'(2); end
      OPCODE_WIDTH'(5): begin c.we = 1'b1; c.aluop = ALUOP_WIDTH'(3); end
      OPCODE_WIDTH'(6): c.jump = 1'b1;
      OPCODE_WIDTH'(7): begin c.sign = 1'b1; c.aluop = ALUOP_WIDTH'(1); c.branch = 1'b1; end
      OPCODE_WIDTH'(8): begin c.we = 1'b1; c.aluop = ALUOP_WIDTH'(4); end
      default:          c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // A new word may enter only when the output slot is free or draining this cycle.
  assign in_ready = (state == IDLE) && (!outValidReg || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign isMult   = (opcode == OP_MULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      outValidReg <= 1'b0;
      ctrlReg     <= '0;
    end else begin
      state       <= nextState;
      counter     <= nextCounter;
      outValidReg <= nextOutValid;
      ctrlReg     <= nextCtrl;
    end
  end

  always_comb begin
    nextState    = state;
    nextCounter  = counter;
    nextOutValid = outValidReg;
    nextCtrl     = ctrlReg;
    if (flush) begin
      nextState    = IDLE;
      nextCounter  = '0;
      nextOutValid = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (isMult) begin
              // Accept implies the old word (if any) retires on this same edge.
              nextState    = MULTI;
              nextCounter  = CW'(MULT_CYCLES - 1);
              nextOutValid = 1'b0;
            end else begin
              nextCtrl     = decode(opcode);
              nextOutValid = 1'b1;
            end
          end else if (outValidReg && out_ready) begin
            nextOutValid = 1'b0;
          end
        end
        MULTI: begin
          nextCounter = counter - CW'(1);
          if (counter == CW'(1)) begin
            nextCtrl     = decode(OP_MULT);
            nextOutValid = 1'b1;
            nextState    = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  assign out_valid   = outValidReg;
  assign busy        = (state == MULTI);
  assign imm         = ctrlReg.imm;
  assign sign        = ctrlReg.sign;
  assign writeenable = ctrlReg.we;
  assign aluop       = ctrlReg.aluop;
  assign jump        = ctrlReg.jump;
  assign branch      = ctrlReg.branch;
  assign illegal     = ctrlReg.illegal;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Scoreboard bench for control_unit_pipelined: expected words are queued on accept
// and compared on retire, with direct checks for latency, hold, flush and reset.
module tb_control_unit_pipelined;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       in_valid, in_ready, out_ready, out_valid, flush;
  logic       imm, sign, writeenable, jump, branch, illegal, busy;
  logic [2:0] aluop;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  control_unit_pipelined #(.OPCODE_WIDTH(8), .ALUOP_WIDTH(3), .MULT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .flush(flush), .imm(imm), .sign(sign),
    .writeenable(writeenable), .aluop(aluop), .jump(jump), .branch(branch),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference word layout: {imm, sign, we, aluop[2:0], jump, branch, illegal}
  function automatic logic [8:0] expectWord(input logic [7:0] op);
    case (op)
      8'h00: return 9'b1_0_1_000_0_0_0;
      8'h01: return 9'b0_0_1_000_0_0_0;
      8'h02: return 9'b0_0_1_001_0_0_0;
      8'h03: return 9'b0_1_1_001_0_0_0;
      8'h04: return 9'b0_0_1_010_0_0_0;
      8'h05: return 9'b0_0_1_011_0_0_0;
      8'h06: return 9'b0_0_0_000_1_0_0;
      8'h07: return 9'b0_1_0_001_0_1_0;
      8'h08: return 9'b0_0_1_100_0_0_0;
      default: return 9'b0_0_0_000_0_0_1;
    endcase
  endfunction

  function automatic logic [8:0] dutWord();
    return {imm, sign, writeenable, aluop, jump, branch, illegal};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic iv, input logic ordy, input logic fl);
    opcode    = op;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are judged mid-cycle, ahead of the edge that acts on them.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checkOutput("sb_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) checkOutput("sb_word", 32'(dutWord()), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(expectWord(opcode));
    end
  end

  initial begin
    logic [7:0] streamOps [4];
    streamOps = '{8'h00, 8'h02, 8'h03, 8'h05};
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_word", 32'(dutWord()), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    $display("[TB] streaming back-to-back");
    foreach (streamOps[i]) begin
      applyStimulus(streamOps[i], 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_word", 32'(dutWord()), 32'(expectWord(streamOps[i])));
    end
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drain", 32'(out_valid), 32'd0);

    $display("[TB] back-pressure hold");
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
      checkOutput("hold_word", 32'(dutWord()), 32'(expectWord(8'h02)));
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("release_word", 32'(dutWord()), 32'(expectWord(8'h00)));
    checkOutput("release_valid", 32'(out_valid), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    $display("[TB] multi-cycle MULT");
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      #1;
      checkOutput("mult_busy", 32'(busy), 32'd1);
      checkOutput("mult_in_ready", 32'(in_ready), 32'd0);
      checkOutput("mult_valid_early", 32'(out_valid), 32'd0);
      tick();
    end
    checkOutput("mult_done_valid", 32'(out_valid), 32'd1);
    checkOutput("mult_done_busy", 32'(busy), 32'd0);
    checkOutput("mult_word", 32'(dutWord()), 32'(expectWord(8'h08)));
    checkOutput("mult_next_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("after_mult_word", 32'(dutWord()), 32'(expectWord(8'h01)));
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    $display("[TB] illegal opcode");
    applyStimulus(8'h3F, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("illegal_valid", 32'(out_valid), 32'd1);
    checkOutput("illegal_word", 32'(dutWord()), 32'(expectWord(8'h3F)));
    applyStimulus(8'h04, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("illegal_cleared", 32'(illegal), 32'd0);
    checkOutput("and_word", 32'(dutWord()), 32'(expectWord(8'h04)));
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    $display("[TB] flush during MULT");
    applyStimulus(8'h08, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("flush_no_mult", 32'(out_valid), 32'd0);
    end
    applyStimulus(8'h02, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("flush_block_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("flush_block_valid", 32'(out_valid), 32'd0);

    $display("[TB] async reset with BEQ held");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("beq_word", 32'(dutWord()), 32'(expectWord(8'h07)));
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_word", 32'(dutWord()), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    sb.delete();
    applyStimulus(8'h02, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_word", 32'(dutWord()), 32'(expectWord(8'h02)));
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
